sd_spi_cmd_master: RTL

//  Host-side SPI-mode SD command engine; sits directly upstream of the SD card (model) on mosi/miso/sclk.

---
 rtl/sd_pkg.sv | 29 ++
 rtl/sd_crc7_serial.sv | 31 +++
 rtl/sd_spi_cmd_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD command path.
// State enum, frame constants, CRC7 polynomial and a frame helper.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SEND,
        POLL,
        CAPT,
        DONE
    } sd_state_e;

    localparam int         CMD_BITS   = 48;
    localparam logic [1:0] START_BITS = 2'b01;
    localparam logic [7:0] R1_TIMEOUT = 8'hFF;
    // x^7 + x^3 + 1 with the x^7 term implicit
    localparam logic [6:0] CRC7_POLY  = 7'h09;

    // Full 48-bit command frame as it appears on mosi, MSB first.
    function automatic logic [CMD_BITS-1:0] sd_frame(
        input logic [5:0]  idx,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        return {START_BITS, idx, arg, crc, 1'b1};
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7+x^3+1, init 0), one bit per enabled clk.
// Ports: clk, rst_n (async low), clr, en, bit_in -> crc[6:0].
module sd_crc7_serial
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] r_crc;
    logic       w_fb;

    assign w_fb = bit_in ^ r_crc[6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= '0;
        end else if (clr) begin
            r_crc <= '0;
        end else if (en) begin
            r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/sd_spi_cmd_master.sv
// Host SPI-mode SD command engine: frames {index,arg,crc7}, polls R1.
// Ports: cmd_valid/ready/index/arg in, rsp_valid/r1/timeout out,
//        busy, and the SPI pins sclk/mosi/miso/cs_n (mode 0).
module sd_spi_cmd_master
    import sd_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int NCR_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        rsp_valid,
    output logic [7:0]  rsp_r1,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    localparam int DIV_W    = $clog2(CLK_DIV + 1);
    localparam int POLL_MAX = NCR_MAX * 8;
    localparam int POLL_W   = $clog2(POLL_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

    sd_state_e           r_state, w_state_n;
    logic [DIV_W-1:0]    r_div, w_div_n;
    logic                r_sclk, w_sclk_n;
    logic                r_mosi, w_mosi_n;
    logic                r_cs_n, w_cs_n_n;
    logic [5:0]          r_idx, w_idx_n;
    logic [31:0]         r_arg, w_arg_n;
    logic [5:0]          r_bit, w_bit_n;
    logic [POLL_W-1:0]   r_poll, w_poll_n;
    logic [5:0]          r_shift, w_shift_n;
    logic [7:0]          r_r1, w_r1_n;
    logic                r_to, w_to_n;

    logic                w_idle;
    logic                w_tick;
    logic                w_rise;
    logic                w_fall;
    logic [CMD_BITS-1:0] w_frame;
    logic [5:0]          w_nxt;
    logic [6:0]          w_crc;
    logic                w_crc_clr;
    logic                w_crc_en;
    logic                w_crc_bit;

    sd_crc7_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_crc_clr),
        .en     (w_crc_en),
        .bit_in (w_crc_bit),
        .crc    (w_crc)
    );

    assign w_idle  = (r_state == IDLE);
    assign w_tick  = !w_idle && (r_div == DIV_LAST);
    assign w_rise  = w_tick && !r_sclk;
    assign w_fall  = w_tick && r_sclk;
    // Bits 47..8 never depend on the CRC, so reading the live CRC
    // register here is safe: it is final before bit 7 is needed.
    assign w_frame = sd_frame(r_idx, r_arg, w_crc);
    // Index of the bit that follows the one currently on mosi.
    assign w_nxt   = 6'd46 - r_bit;

    always_comb begin
        w_state_n = r_state;
        w_div_n   = (w_idle || w_tick) ? '0 : r_div + DIV_W'(1);
        w_sclk_n  = w_tick ? ~r_sclk : r_sclk;
        w_mosi_n  = r_mosi;
        w_cs_n_n  = r_cs_n;
        w_idx_n   = r_idx;
        w_arg_n   = r_arg;
        w_bit_n   = r_bit;
        w_poll_n  = r_poll;
        w_shift_n = r_shift;
        w_r1_n    = r_r1;
        w_to_n    = r_to;
        w_crc_clr = 1'b0;
        w_crc_en  = 1'b0;
        w_crc_bit = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_sclk_n = 1'b0;
                if (cmd_valid) begin
                    w_idx_n   = cmd_index;
                    w_arg_n   = cmd_arg;
                    w_crc_clr = 1'b1;
                    w_cs_n_n  = 1'b0;
                    w_mosi_n  = 1'b1;
                    w_bit_n   = '0;
                    w_poll_n  = '0;
                    w_state_n = PRE;
                end
            end
            PRE: begin
                if (w_fall) begin
                    if (r_bit == 6'd7) begin
                        w_mosi_n  = w_frame[CMD_BITS-1];
                        w_crc_en  = 1'b1;
                        w_crc_bit = w_frame[CMD_BITS-1];
                        w_bit_n   = '0;
                        w_state_n = SEND;
                    end else begin
                        w_bit_n = r_bit + 6'd1;
                    end
                end
            end
            SEND: begin
                if (w_fall) begin
                    if (r_bit == 6'd47) begin
                        w_mosi_n  = 1'b1;
                        w_poll_n  = '0;
                        w_state_n = POLL;
                    end else begin
                        w_mosi_n = w_frame[w_nxt];
                        w_bit_n  = r_bit + 6'd1;
                        // Only the 40 header/argument bits feed the CRC.
                        if (r_bit < 6'd39) begin
                            w_crc_en  = 1'b1;
                            w_crc_bit = w_frame[w_nxt];
                        end
                    end
                end
            end
            POLL: begin
                if (w_rise) begin
                    if (!miso) begin
                        // This 0 is R1 bit 7; seven bits remain.
                        w_shift_n = '0;
                        w_bit_n   = 6'd1;
                        w_state_n = CAPT;
                    end else if (r_poll == POLL_LAST) begin
                        w_r1_n    = R1_TIMEOUT;
                        w_to_n    = 1'b1;
                        w_state_n = DONE;
                    end else begin
                        w_poll_n = r_poll + POLL_W'(1);
                    end
                end
            end
            CAPT: begin
                if (w_rise) begin
                    w_shift_n = {r_shift[4:0], miso};
                    if (r_bit == 6'd7) begin
                        w_r1_n    = {1'b0, r_shift, miso};
                        w_to_n    = 1'b0;
                        w_state_n = DONE;
                    end else begin
                        w_bit_n = r_bit + 6'd1;
                    end
                end
            end
            DONE: begin
                w_div_n   = '0;
                w_sclk_n  = 1'b0;
                w_mosi_n  = 1'b1;
                w_cs_n_n  = 1'b1;
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b1;
            r_cs_n  <= 1'b1;
            r_idx   <= '0;
            r_arg   <= '0;
            r_bit   <= '0;
            r_poll  <= '0;
            r_shift <= '0;
            r_r1    <= R1_TIMEOUT;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_sclk  <= w_sclk_n;
            r_mosi  <= w_mosi_n;
            r_cs_n  <= w_cs_n_n;
            r_idx   <= w_idx_n;
            r_arg   <= w_arg_n;
            r_bit   <= w_bit_n;
            r_poll  <= w_poll_n;
            r_shift <= w_shift_n;
            r_r1    <= w_r1_n;
            r_to    <= w_to_n;
        end
    end

    assign cmd_ready   = w_idle;
    assign busy        = !w_idle;
    assign rsp_valid   = (r_state == DONE);
    assign rsp_r1      = r_r1;
    assign rsp_timeout = r_to;
    assign sclk        = r_sclk;
    assign mosi        = r_mosi;
    assign cs_n        = r_cs_n;

endmodule
